// File: rtl/aes_round_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES block controller. Runs a complete NR-round encryption or
// decryption on one DATA_W-bit block by time-sharing an external single-round
// datapath. The round-key store also sits outside; this block drives its
// index and consumes the selected key combinationally in the same cycle.
//
// Flow per block: IDLE (accept) -> ARK (initial AddRoundKey) ->
//                 { ISSUE -> WAIT } x NR -> DONE (hold result until taken).
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/ready    input block handshake; in_mode 0=encrypt 1=decrypt
//   in_data, in_tag   input block and user tag
//   out_valid/ready   result handshake; out_data, out_tag result and its tag
//   key_idx           registered round-key index to the key store
//   rk                round key at key_idx (combinational)
//   rnd_valid         one-cycle issue strobe to the round unit
//   rnd_state/key     round unit operands (held stable while waiting)
//   rnd_mode          latched mode; rnd_last marks the final round
//   rnd_out(_valid)   round unit result
//   busy              high whenever not IDLE
//   err               sticky: round result strobe seen outside WAIT
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int DATA_W = 128,
  parameter int NR     = 10,
  parameter int TAG_W  = 4,
  parameter int KI_W   = $clog2(NR + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [KI_W-1:0]   key_idx,
  input  logic [DATA_W-1:0] rk,
  output logic              rnd_valid,
  output logic [DATA_W-1:0] rnd_state,
  output logic [DATA_W-1:0] rnd_key,
  output logic              rnd_mode,
  output logic              rnd_last,
  input  logic [DATA_W-1:0] rnd_out,
  input  logic              rnd_out_valid,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [KI_W-1:0] NR_K  = KI_W'(NR);
  localparam logic [KI_W-1:0] ONE_K = KI_W'(1);

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] st_q,      st_d;
  logic              mode_q,    mode_d;
  logic [TAG_W-1:0]  tag_q,     tag_d;
  logic [KI_W-1:0]   round_q,   round_d;
  logic [KI_W-1:0]   key_idx_q, key_idx_d;
  logic              err_q,     err_d;

  // Encrypt walks the key schedule upwards, decrypt downwards. The index is
  // only stepped NR times per block, so it never leaves 0..NR.
  logic [KI_W-1:0]   key_step;
  assign key_step = mode_q ? (key_idx_q - ONE_K) : (key_idx_q + ONE_K);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      st_q      <= '0;
      mode_q    <= 1'b0;
      tag_q     <= '0;
      round_q   <= '0;
      key_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      mode_q    <= mode_d;
      tag_q     <= tag_d;
      round_q   <= round_d;
      key_idx_q <= key_idx_d;
      err_q     <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    mode_d    = mode_q;
    tag_d     = tag_q;
    round_d   = round_q;
    key_idx_d = key_idx_q;
    // A round result arriving when nothing is outstanding is dropped and
    // flagged; the state register is never touched by it.
    err_d     = err_q | (rnd_out_valid && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d      = in_data;
          mode_d    = in_mode;
          tag_d     = in_tag;
          round_d   = ONE_K;
          key_idx_d = in_mode ? NR_K : '0;
          state_d   = S_ARK;
        end
      end

      S_ARK: begin
        st_d      = st_q ^ rk;
        key_idx_d = key_step;
        state_d   = S_ISSUE;
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (rnd_out_valid) begin
          st_d = rnd_out;
          if (round_q == NR_K) begin
            // Key index stays on its final value until the next accept.
            state_d = S_DONE;
          end else begin
            round_d   = round_q + ONE_K;
            key_idx_d = key_step;
            state_d   = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);

  // Intermediate round states are not exposed on the result port.
  assign out_data  = (state_q == S_DONE) ? st_q  : '0;
  assign out_tag   = (state_q == S_DONE) ? tag_q : '0;

  assign key_idx   = key_idx_q;
  assign rnd_valid = (state_q == S_ISSUE);
  assign rnd_state = st_q;
  assign rnd_key   = rk;
  assign rnd_mode  = mode_q;
  // Held through WAIT so the round unit may sample it at any point.
  assign rnd_last  = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (round_q == NR_K);
  assign err       = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Directed bench for the AES round sequencer. The bench plays the roles of
// the external key store (AES-128 key schedule) and a single-round unit with
// configurable latency. Expected results are the FIPS-197 example vectors.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

  localparam int DATA_W = 128;
  localparam int NR     = 10;
  localparam int TAG_W  = 4;
  localparam int KI_W   = $clog2(NR + 1);

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [KI_W-1:0]   key_idx;
  logic [DATA_W-1:0] rk;
  logic              rnd_valid;
  logic [DATA_W-1:0] rnd_state;
  logic [DATA_W-1:0] rnd_key;
  logic              rnd_mode;
  logic              rnd_last;
  logic [DATA_W-1:0] rnd_out;
  logic              rnd_out_valid;
  logic              busy;
  logic              err;

  aes_round_sequencer #(
    .DATA_W(DATA_W), .NR(NR), .TAG_W(TAG_W), .KI_W(KI_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .key_idx(key_idx), .rk(rk),
    .rnd_valid(rnd_valid), .rnd_state(rnd_state), .rnd_key(rnd_key),
    .rnd_mode(rnd_mode), .rnd_last(rnd_last),
    .rnd_out(rnd_out), .rnd_out_valid(rnd_out_valid),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- tables
  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rks      [0:NR];

  assign rk = (int'(key_idx) <= NR) ? rks[key_idx] : '0;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;
  int spur_cnt = 0;

  // Written only by the round model process.
  int              issue_n;
  logic [KI_W-1:0] kidx_log [16];
  logic            last_log [16];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gm(inv, 8'(x));
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Bytes are numbered from the MSB; state is column-major (idx = row + 4*col).
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) a[r+4*c] = b[r+4*c];
      end else begin
        a[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*((c+r)%4)] = s[127-8*(r+4*c) -: 8];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox[b[i]];
    o = o ^ k;
    if (!last) begin
      for (int i = 0; i < 16; i++) b[i] = o[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
        a[4*c]   = gm(b[4*c],8'h0e) ^ gm(b[4*c+1],8'h0b) ^ gm(b[4*c+2],8'h0d) ^ gm(b[4*c+3],8'h09);
        a[4*c+1] = gm(b[4*c],8'h09) ^ gm(b[4*c+1],8'h0e) ^ gm(b[4*c+2],8'h0b) ^ gm(b[4*c+3],8'h0d);
        a[4*c+2] = gm(b[4*c],8'h0d) ^ gm(b[4*c+1],8'h09) ^ gm(b[4*c+2],8'h0e) ^ gm(b[4*c+3],8'h0b);
        a[4*c+3] = gm(b[4*c],8'h0b) ^ gm(b[4*c+1],8'h0d) ^ gm(b[4*c+2],8'h09) ^ gm(b[4*c+3],8'h0e);
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    end
    return o;
  endfunction

  // ----------------------------------------------------------- round model
  initial begin : round_model
    int           spur_seen;
    logic [127:0] s_cap;
    logic [127:0] k_cap;
    logic [127:0] res;
    logic         m_cap;
    logic         l_cap;
    spur_seen     = 0;
    issue_n       = 0;
    rnd_out_valid = 1'b0;
    rnd_out       = '0;
    forever begin
      @(negedge clk);
      if (!busy) issue_n = 0;
      if (spur_cnt != spur_seen) begin
        spur_seen     = spur_cnt;
        rnd_out       = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        rnd_out_valid = 1'b1;
        @(posedge clk);
        #1 rnd_out_valid = 1'b0;
      end else if (rnd_valid) begin
        issue_n++;
        if (issue_n < 16) begin
          kidx_log[issue_n] = key_idx;
          last_log[issue_n] = rnd_last;
        end
        s_cap = rnd_state;
        k_cap = rnd_key;
        m_cap = rnd_mode;
        l_cap = rnd_last;
        res   = m_cap ? dec_round(s_cap, k_cap, l_cap) : enc_round(s_cap, k_cap, l_cap);
        repeat (lat) @(posedge clk);
        #1;
        rnd_out       = res;
        rnd_out_valid = 1'b1;
        @(posedge clk);
        #1 rnd_out_valid = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- helpers
  // Called #1 after the accept edge; cyc counts edges from the accept edge.
  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    if (!seen) chk("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic check_log(input logic mode);
    chk("n_issue", issue_n, NR);
    for (int r = 1; r <= NR; r++) begin
      chk($sformatf("kidx_issue%0d", r), kidx_log[r], mode ? (NR - r) : r);
      chk($sformatf("last_issue%0d", r), last_log[r], (r == NR));
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("ov_clear", out_valid, 1'b0);
    chk("ready_back", in_ready, 1'b1);
  endtask

  task automatic run_block(input logic mode, input logic [127:0] data, input logic [3:0] tag,
                           input logic [127:0] exp, input int exp_lat);
    int cyc;
    @(negedge clk);
    in_mode  = mode;
    in_data  = data;
    in_tag   = tag;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("ark_kidx", key_idx, mode ? NR : 0);
    chk("busy_run", busy, 1'b1);
    wait_done(cyc);
    chk("latency", cyc, exp_lat);
    chk("out_data", out_data, exp);
    chk("out_tag", out_tag, tag);
    chk("kidx_end", key_idx, mode ? 0 : NR);
    check_log(mode);
    finish_out();
    $display("block mode=%0d tag=%0d out=%h lat=%0d", mode, tag, exp, cyc);
  endtask

  // ------------------------------------------------------------ main flow
  initial begin : main
    int cyc;
    bit found;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    build_tables();
    expand_key(KEY);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_kidx", key_idx, 0);
    chk("rst_rnd_valid", rnd_valid, 1'b0);
    chk("rst_rnd_last", rnd_last, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    rst_n = 1'b1;

    // FIPS-197 encrypt and decrypt, round latency 1
    run_block(1'b0, PT, 4'd1, CT, 22);
    run_block(1'b1, CT, 4'd4, PT, 22);
    chk("err_after_normal", err, 1'b0);

    // Backpressure with a second block waiting
    @(negedge clk);
    in_mode  = 1'b0;
    in_data  = PT;
    in_tag   = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_mode = 1'b1;
    in_data = CT;
    in_tag  = 4'd5;
    wait_done(cyc);
    chk("bp_latency", cyc, 22);
    check_log(1'b0);
    for (int i = 0; i < 15; i++) begin
      chk("bp_data", out_data, CT);
      chk("bp_tag", out_tag, 4'd3);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    $display("block mode=0 tag=3 out=%h stalled 15 cycles", CT);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1'b1);
    chk("bp_idle_busy", busy, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_second_busy", busy, 1'b1);
    chk("bp_second_kidx", key_idx, NR);
    wait_done(cyc);
    chk("bp2_latency", cyc, 22);
    chk("bp2_data", out_data, PT);
    chk("bp2_tag", out_tag, 4'd5);
    check_log(1'b1);
    finish_out();
    $display("block mode=1 tag=5 out=%h lat=%0d", PT, cyc);

    // Round unit latency 3
    lat = 3;
    run_block(1'b0, PT, 4'd2, CT, 42);
    lat = 1;

    // Reset during round 5 WAIT
    @(negedge clk);
    in_mode  = 1'b0;
    in_data  = PT;
    in_tag   = 4'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (issue_n == 5) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_reached_round5", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_kidx", key_idx, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-operation applied at round 5");
    run_block(1'b0, PT, 4'd7, CT, 22);
    chk("err_after_reset", err, 1'b0);

    // Spurious round strobe in IDLE; state register must keep last result
    @(posedge clk);
    #1 spur_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_err", err, 1'b1);
    chk("spur_state_kept", rnd_state, CT);
    chk("spur_idle", in_ready, 1'b1);
    $display("spurious rnd_out_valid in IDLE, err=%0d", err);
    run_block(1'b0, PT, 4'd9, CT, 22);
    chk("err_sticky", err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
